// File: rtl/swap_pkg.sv
// Shared types and defaults for the swap sequencer: FSM state encoding and counter width.
package swap_pkg;

  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SWAP = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/swap_seq_ctrl_if.sv
// Command/status bundle between a requester and the swap sequencer.
interface swap_seq_ctrl_if #(
  parameter int CNT_W = swap_pkg::CNT_W_DEF
);

  logic             start_i;
  logic             abort_i;
  logic             a_i;
  logic             b_i;
  logic [CNT_W-1:0] len_i;
  logic             a_o;
  logic             b_o;
  logic             busy_o;
  logic             done_o;
  logic             aborted_o;
  logic [CNT_W-1:0] swap_cnt_o;

  modport master (
    output start_i, abort_i, a_i, b_i, len_i,
    input  a_o, b_o, busy_o, done_o, aborted_o, swap_cnt_o
  );

  modport slave (
    input  start_i, abort_i, a_i, b_i, len_i,
    output a_o, b_o, busy_o, done_o, aborted_o, swap_cnt_o
  );

endinterface

// File: rtl/swap_pair.sv
// A/B register pair: parallel load or simultaneous exchange, load wins.
module swap_pair (
  input  logic clk,
  input  logic rst_n,
  input  logic load_en,
  input  logic swap_en,
  input  logic a_i,
  input  logic b_i,
  output logic a_o,
  output logic b_o
);

  logic a_q;
  logic b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= 1'b0;
      b_q <= 1'b0;
    end else if (load_en) begin
      a_q <= a_i;
      b_q <= b_i;
    end else if (swap_en) begin
      a_q <= b_q;
      b_q <= a_q;
    end
  end

  assign a_o = a_q;
  assign b_o = b_q;

endmodule

// File: rtl/swap_seq_ctrl.sv
// Swap sequencer: loads A/B, exchanges them len times (abortable), then pulses done.
module swap_seq_ctrl
  import swap_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input logic             clk,
  input logic             rst_n,
  swap_seq_ctrl_if.slave  bus
);

  state_e           state_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;

  logic load_en;
  logic swap_en;
  logic last_swap;

  // An abort coinciding with the final swap is ignored so the sequence completes normally.
  assign last_swap = (rem_q == CNT_W'(1));
  assign load_en   = (state_q == IDLE) && bus.start_i;
  assign swap_en   = (state_q == SWAP) && !(bus.abort_i && !last_swap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            rem_q     <= bus.len_i;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b1;
            if (bus.len_i != '0) begin
              state_q <= SWAP;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        SWAP: begin
          if (swap_en) begin
            rem_q <= rem_q - CNT_W'(1);
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_swap) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else begin
            aborted_q <= 1'b1;
            state_q   <= DONE;
            done_q    <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  swap_pair u_pair (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (load_en),
    .swap_en (swap_en),
    .a_i     (bus.a_i),
    .b_i     (bus.b_i),
    .a_o     (bus.a_o),
    .b_o     (bus.b_o)
  );

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.aborted_o  = aborted_q;
  assign bus.swap_cnt_o = cnt_q;

endmodule

// File: tb/tb_swap_seq_ctrl.sv
// Bench for swap_seq_ctrl: time-since-start reference model, directed cases and random traffic.
module tb_swap_seq_ctrl;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  swap_seq_ctrl_if #(.CNT_W(W)) bus ();

  swap_seq_ctrl #(.CNT_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: m_e = edges since the accepted start, m_E = edge at which DONE is entered.
  int m_e, m_E, m_N;
  bit m_a0, m_b0, m_ab;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_a0 = 0; m_b0 = 0; m_N = 0; m_E = 0; m_ab = 0; m_e = 1;
  endfunction

  function automatic void model_edge(bit s, bit ab, bit a, bit b, int l);
    if (m_e > m_E) begin
      if (s) begin
        m_e = 0; m_a0 = a; m_b0 = b; m_N = l; m_E = l; m_ab = 0;
      end
    end else begin
      if (m_e < m_E && ab && (m_e + 1) < m_N) begin
        m_ab = 1;
        m_E  = m_e + 1;
      end
      m_e++;
    end
  endfunction

  function automatic int m_swaps();
    if (m_ab) return m_E - 1;
    return (m_e < m_E) ? m_e : m_E;
  endfunction

  task automatic compare();
    int sw;
    sw = m_swaps();
    chk("a_o",        bus.a_o,        (sw % 2) ? m_b0 : m_a0);
    chk("b_o",        bus.b_o,        (sw % 2) ? m_a0 : m_b0);
    chk("swap_cnt_o", bus.swap_cnt_o, sw);
    chk("busy_o",     bus.busy_o,     (m_e <= m_E) ? 1 : 0);
    chk("done_o",     bus.done_o,     (m_e == m_E) ? 1 : 0);
    chk("aborted_o",  bus.aborted_o,  m_ab);
  endtask

  task automatic cycle(input bit s, input bit ab, input bit a, input bit b, input int l);
    bus.start_i = s; bus.abort_i = ab; bus.a_i = a; bus.b_i = b; bus.len_i = W'(l);
    @(posedge clk);
    model_edge(s, ab, a, b, l);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.start_i = 0; bus.abort_i = 0; bus.a_i = 0; bus.b_i = 0; bus.len_i = '0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_cnt",  bus.swap_cnt_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // len=3, a=1 b=0, start accepted on the first edge after reset release
    cycle(1, 0, 1, 0, 3);
    chk("l3_k_busy", bus.busy_o, 1);
    cycle(0, 0, 0, 0, 0); chk("l3_k1_a", bus.a_o, 0); chk("l3_k1_b", bus.b_o, 1);
    cycle(0, 0, 0, 0, 0); chk("l3_k2_a", bus.a_o, 1); chk("l3_k2_b", bus.b_o, 0);
    cycle(0, 0, 0, 0, 0); chk("l3_k3_a", bus.a_o, 0); chk("l3_k3_b", bus.b_o, 1);
    chk("l3_done", bus.done_o, 1); chk("l3_cnt", bus.swap_cnt_o, 3); chk("l3_ab", bus.aborted_o, 0);
    cycle(0, 0, 0, 0, 0); chk("l3_done_gone", bus.done_o, 0);
    idle(1);

    // len=0: immediate done, no swap
    cycle(1, 0, 1, 0, 0);
    chk("l0_done", bus.done_o, 1); chk("l0_a", bus.a_o, 1); chk("l0_b", bus.b_o, 0);
    chk("l0_cnt", bus.swap_cnt_o, 0);
    idle(2);

    // len=5, abort at edge k+2
    cycle(1, 0, 1, 0, 5);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("ab_done", bus.done_o, 1); chk("ab_flag", bus.aborted_o, 1);
    chk("ab_cnt", bus.swap_cnt_o, 1); chk("ab_a", bus.a_o, 0); chk("ab_b", bus.b_o, 1);
    idle(2);
    chk("ab_hold", bus.aborted_o, 1);

    // len=2, abort on the final-swap edge is ignored
    cycle(1, 0, 0, 1, 2);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("abl_done", bus.done_o, 1); chk("abl_cnt", bus.swap_cnt_o, 2); chk("abl_flag", bus.aborted_o, 0);
    idle(1);

    // start held high across SWAP and DONE
    cycle(1, 0, 1, 0, 2);
    cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 1);
    chk("hold_done", bus.done_o, 1); chk("hold_cnt", bus.swap_cnt_o, 2);
    cycle(1, 0, 0, 1, 1);
    chk("hold_idle_busy", bus.busy_o, 0);
    cycle(1, 0, 0, 1, 1);
    chk("hold_restart_busy", bus.busy_o, 1); chk("hold_restart_a", bus.a_o, 0);
    chk("hold_restart_cnt", bus.swap_cnt_o, 0);
    cycle(0, 0, 0, 0, 0);
    chk("hold_restart_done", bus.done_o, 1);
    idle(1);

    // maximum length
    cycle(1, 0, 1, 0, 15);
    for (int i = 0; i < 15; i++) cycle(0, 0, 0, 0, 0);
    chk("max_done", bus.done_o, 1); chk("max_cnt", bus.swap_cnt_o, 15);
    chk("max_a", bus.a_o, 0);
    idle(1);

    // asynchronous reset between edges, mid-SWAP
    cycle(1, 0, 1, 1, 6);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_a", bus.a_o, 0); chk("arst_b", bus.b_o, 0); chk("arst_busy", bus.busy_o, 0);
    chk("arst_cnt", bus.swap_cnt_o, 0); chk("arst_done", bus.done_o, 0);
    #1 rst_n = 1'b1;
    model_reset();
    idle(8);
    cycle(1, 0, 0, 1, 1);
    chk("arst_restart_busy", bus.busy_o, 1); chk("arst_restart_b", bus.b_o, 1);
    idle(2);

    // random traffic, checked every cycle against the model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 2),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/swap_seq_ctrl.md
SWAP_SEQ_CTRL -- requirements
Module: swap_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 4: width of the swap-length field and the swap counter.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start_i, input, 1: request to run one swap sequence; sampled only in IDLE.
REQ-005 SHALL have port abort_i, input, 1: terminate the running sequence early; sampled only in SWAP.
REQ-006 SHALL have port a_i, input, 1: operand A, captured on an accepted start.
REQ-007 SHALL have port b_i, input, 1: operand B, captured on an accepted start.
REQ-008 SHALL have port len_i, input, CNT_W: number of swap cycles to perform, captured on an accepted start.
REQ-009 SHALL have port a_o, output, 1: current content of register A.
REQ-010 SHALL have port b_o, output, 1: current content of register B.
REQ-011 SHALL have port busy_o, output, 1: high in the SWAP and DONE states.
REQ-012 SHALL have port done_o, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port aborted_o, output, 1: valid with done_o; high when the sequence ended by abort.
REQ-014 SHALL have port swap_cnt_o, output, CNT_W: swaps performed in the current or last sequence.

Function
REQ-015 SHALL implement the FSM states IDLE, SWAP and DONE; all outputs SHALL be registered.
REQ-016 SHALL, in IDLE with start_i=1 at edge k, load A<=a_i, B<=b_i, remaining<=len_i and swap_cnt<=0.
REQ-017 SHALL, on the start of REQ-016, enter SWAP after edge k when len_i is nonzero, and DONE when len_i is zero.
REQ-018 SHALL, on each SWAP edge, exchange A and B simultaneously (A<=B, B<=A from pre-edge values), decrement remaining and increment swap_cnt.
REQ-019 SHALL leave SWAP for DONE on the edge that performs the swap with remaining==1.
REQ-020 SHALL, for len_i=N>0 with start at edge k, show the final swap after edge k+N and assert done_o during cycle k+N+1 only.
REQ-021 SHALL, when abort_i=1 in SWAP, perform no swap on that edge, freeze A, B and swap_cnt, set aborted, and enter DONE.
REQ-022 SHALL, when abort_i=1 on the same edge as the final swap (remaining==1), complete the swap and leave aborted_o=0.
REQ-023 SHALL hold done_o=1 for exactly one cycle in DONE and return to IDLE on the next edge.
REQ-024 SHALL ignore start_i in SWAP and DONE; back-to-back starts are accepted only from IDLE.
REQ-025 SHALL ignore abort_i in IDLE and DONE.
REQ-026 SHALL hold a_o, b_o, swap_cnt_o and aborted_o stable in IDLE until the next accepted start.
REQ-027 SHALL accept len_i at its maximum value (2^CNT_W-1) without wrap; swap_cnt_o SHALL end equal to len_i.

Reset
REQ-028 SHALL, while rst_n=0, force IDLE and a_o=0, b_o=0, busy_o=0, done_o=0, aborted_o=0, swap_cnt_o=0 immediately, independent of clk.
REQ-029 SHALL, on reset mid-sequence, discard the sequence without producing a done_o pulse.
REQ-030 SHALL, after rst_n deasserts, accept start_i at the first rising clk edge.

Structure
REQ-031 SHALL take the FSM state enum and the CNT_W default from the shared package swap_pkg.
REQ-032 SHALL instantiate the A/B register pair as sub-module swap_pair (ports clk, rst_n, load_en, swap_en, a_i, b_i, a_o, b_o), with load_en taking priority over swap_en.

Verification
REQ-033 SHALL cover: a_i=1, b_i=0, len_i=3, start at edge k -> a_o/b_o read 0/1, 1/0, 0/1 after edges k+1..k+3; done_o high in cycle k+4; swap_cnt_o=3; aborted_o=0.
REQ-034 SHALL cover: len_i=0, a_i=1, b_i=0 -> no swap; done_o high in cycle k+1; a_o=1, b_o=0; swap_cnt_o=0.
REQ-035 SHALL cover: len_i=5, abort_i high at edge k+2 -> swap_cnt_o=1, a_o/b_o show one swap, done_o and aborted_o both high in cycle k+3.
REQ-036 SHALL cover: len_i=2 with abort_i high at the final-swap edge k+2 -> swap_cnt_o=2, aborted_o=0.
REQ-037 SHALL cover: start_i held high throughout SWAP and DONE -> no restart until IDLE, next sequence captured one edge after done_o.
REQ-038 SHALL cover: rst_n pulsed low mid-SWAP between clk edges -> outputs zero asynchronously, no done_o pulse, normal start afterwards.
